// File: rtl/reg_file_sb_if.sv
// reg_file_sb_if: bus bundle for the register file with scoreboard.
//   read ports   : ra1/ra2 -> rd1/rd2, busy1/busy2
//   write ports  : we0/wa0/wd0 (low priority), we1/wa1/wd1 (high priority)
//   issue port   : iss_we/iss_wa marks a register pending
//   status       : pend_cnt, registered count of pending registers
// The master modport is the core pipeline; the slave modport is the register file.
interface reg_file_sb_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              busy1;
  logic              busy2;
  logic              we0;
  logic [ADDR_W-1:0] wa0;
  logic [DATA_W-1:0] wd0;
  logic              we1;
  logic [ADDR_W-1:0] wa1;
  logic [DATA_W-1:0] wd1;
  logic              iss_we;
  logic [ADDR_W-1:0] iss_wa;
  logic [ADDR_W:0]   pend_cnt;

  modport master (
    output ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_we, iss_wa,
    input  rd1, rd2, busy1, busy2, pend_cnt
  );

  modport slave (
    input  ra1, ra2, we0, wa0, wd0, we1, wa1, wd1, iss_we, iss_wa,
    output rd1, rd2, busy1, busy2, pend_cnt
  );
endinterface

// File: rtl/reg_file_sb.sv
// reg_file_sb: general-purpose register file with a write-pending scoreboard.
//   clk  : clock, all state changes on the rising edge
//   rst  : asynchronous reset, active-high
//   bus  : reg_file_sb_if.slave (two combinational read ports, two writeback
//          ports, one issue port, registered pending count)
// Register 0 and addresses >= NREG are null: they read as zero, are never
// pending, and writes/issues to them are dropped. Null handling falls out of
// the per-register loops below, which only ever match addresses 1..NREG-1.
module reg_file_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREG   = 32,
  parameter int BYPASS = 1
) (
  input logic          clk,
  input logic          rst,
  reg_file_sb_if.slave bus
);

  logic [DATA_W-1:0] gpr_q [1:NREG-1];
  logic [DATA_W-1:0] gpr_d [1:NREG-1];
  logic [NREG-1:1]   pend_q;
  logic [NREG-1:1]   pend_d;
  logic [ADDR_W:0]   pend_cnt_q;
  logic [ADDR_W:0]   pend_cnt_d;

  logic [NREG-1:1]   wr0_v;
  logic [NREG-1:1]   wr1_v;
  logic [NREG-1:1]   set_v;
  logic [NREG-1:1]   clr_v;
  logic              byp_en;

  // Forwarding is suppressed during reset so the read ports show zero even
  // when the write ports are active.
  assign byp_en = (BYPASS != 0) && !rst;

  always_comb begin
    wr0_v = '0;
    wr1_v = '0;
    set_v = '0;
    for (int r = 1; r < NREG; r++) begin
      wr0_v[r] = bus.we0    && (bus.wa0    == ADDR_W'(r));
      wr1_v[r] = bus.we1    && (bus.wa1    == ADDR_W'(r));
      set_v[r] = bus.iss_we && (bus.iss_wa == ADDR_W'(r));
    end
    clr_v = wr0_v | wr1_v;
  end

  always_comb begin
    gpr_d = gpr_q;
    for (int r = 1; r < NREG; r++) begin
      if (wr1_v[r]) begin
        gpr_d[r] = bus.wd1;
      end else if (wr0_v[r]) begin
        gpr_d[r] = bus.wd0;
      end
    end
    // A new issue supersedes a writeback of an older instruction.
    pend_d     = set_v | (pend_q & ~clr_v);
    pend_cnt_d = '0;
    for (int r = 1; r < NREG; r++) begin
      pend_cnt_d = pend_cnt_d + (ADDR_W+1)'(pend_d[r]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 1; r < NREG; r++) begin
        gpr_q[r] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      gpr_q      <= gpr_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  always_comb begin
    bus.rd1   = '0;
    bus.rd2   = '0;
    bus.busy1 = 1'b0;
    bus.busy2 = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      if (bus.ra1 == ADDR_W'(r)) begin
        bus.rd1   = gpr_q[r];
        bus.busy1 = pend_q[r] & ~(byp_en & clr_v[r]);
        if (byp_en && wr1_v[r]) begin
          bus.rd1 = bus.wd1;
        end else if (byp_en && wr0_v[r]) begin
          bus.rd1 = bus.wd0;
        end
      end
      if (bus.ra2 == ADDR_W'(r)) begin
        bus.rd2   = gpr_q[r];
        bus.busy2 = pend_q[r] & ~(byp_en & clr_v[r]);
        if (byp_en && wr1_v[r]) begin
          bus.rd2 = bus.wd1;
        end else if (byp_en && wr0_v[r]) begin
          bus.rd2 = bus.wd0;
        end
      end
    end
  end

  assign bus.pend_cnt = pend_cnt_q;

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_b1  ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_b0  ();
  reg_file_sb_if #(.DATA_W(32), .ADDR_W(5)) if_n16 ();

  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NREG(32), .BYPASS(1)) u_b1  (.clk(clk), .rst(rst), .bus(if_b1));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NREG(32), .BYPASS(0)) u_b0  (.clk(clk), .rst(rst), .bus(if_b0));
  reg_file_sb #(.DATA_W(32), .ADDR_W(5), .NREG(16), .BYPASS(1)) u_n16 (.clk(clk), .rst(rst), .bus(if_n16));

  task automatic idle_all();
    if_b1.ra1 = '0;  if_b1.ra2 = '0;  if_b1.we0 = 0;  if_b1.wa0 = '0;  if_b1.wd0 = '0;
    if_b1.we1 = 0;   if_b1.wa1 = '0;  if_b1.wd1 = '0; if_b1.iss_we = 0; if_b1.iss_wa = '0;
    if_b0.ra1 = '0;  if_b0.ra2 = '0;  if_b0.we0 = 0;  if_b0.wa0 = '0;  if_b0.wd0 = '0;
    if_b0.we1 = 0;   if_b0.wa1 = '0;  if_b0.wd1 = '0; if_b0.iss_we = 0; if_b0.iss_wa = '0;
    if_n16.ra1 = '0; if_n16.ra2 = '0; if_n16.we0 = 0; if_n16.wa0 = '0; if_n16.wd0 = '0;
    if_n16.we1 = 0;  if_n16.wa1 = '0; if_n16.wd1 = '0; if_n16.iss_we = 0; if_n16.iss_wa = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h0 || if_b1.pend_cnt !== 6'd0 || if_b1.busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: rd1=%h cnt=%0d busy1=%b expected 0/0/0", if_b1.rd1, if_b1.pend_cnt, if_b1.busy1);
    end
    tick();
    rst = 1'b0;
    if_b1.we1 = 1; if_b1.wa1 = 5'd5; if_b1.wd1 = 32'hDEADBEEF;
    if_b1.iss_we = 1; if_b1.iss_wa = 5'd6;
    tick();
    if_b1.we1 = 0; if_b1.iss_we = 0; if_b1.ra1 = 5'd5; if_b1.ra2 = 5'd6;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'hDEADBEEF || if_b1.pend_cnt !== 6'd1 || if_b1.busy2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_prewrite: rd1=%h cnt=%0d busy2=%b expected deadbeef/1/1", if_b1.rd1, if_b1.pend_cnt, if_b1.busy2);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h0 || if_b1.pend_cnt !== 6'd0 || if_b1.busy2 !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rd1=%h cnt=%0d busy2=%b expected 0/0/0", if_b1.rd1, if_b1.pend_cnt, if_b1.busy2);
    end
    if_b1.we1 = 1; if_b1.wa1 = 5'd5; if_b1.wd1 = 32'h12345678;
    if_b1.iss_we = 1; if_b1.iss_wa = 5'd5;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h0) begin
      errors++;
      $display("FAIL reset_no_bypass: rd1=%h expected 0", if_b1.rd1);
    end
    tick();
    rst = 1'b0;
    if_b1.we1 = 0; if_b1.iss_we = 0;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h0 || if_b1.pend_cnt !== 6'd0 || if_b1.busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_discard: rd1=%h cnt=%0d busy1=%b expected 0/0/0", if_b1.rd1, if_b1.pend_cnt, if_b1.busy1);
    end
    tick();
  endtask

  task automatic test_zero_reg();
    if_b1.ra1 = 5'd0;
    if_b1.we1 = 1; if_b1.wa1 = 5'd0; if_b1.wd1 = 32'hFFFFFFFF;
    if_b1.iss_we = 1; if_b1.iss_wa = 5'd0;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h0) begin
      errors++;
      $display("FAIL zero_bypass: rd1=%h expected 0", if_b1.rd1);
    end
    tick();
    if_b1.we1 = 0; if_b1.iss_we = 0;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h0 || if_b1.busy1 !== 1'b0 || if_b1.pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL zero_reg: rd1=%h busy1=%b cnt=%0d expected 0/0/0", if_b1.rd1, if_b1.busy1, if_b1.pend_cnt);
    end
  endtask

  task automatic test_priority_bypass();
    if_b1.ra1 = 5'd7;
    if_b1.we0 = 1; if_b1.wa0 = 5'd7; if_b1.wd0 = 32'h11;
    if_b1.we1 = 1; if_b1.wa1 = 5'd7; if_b1.wd1 = 32'h22;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h22) begin
      errors++;
      $display("FAIL prio_bypass: rd1=%h expected 22", if_b1.rd1);
    end
    tick();
    if_b1.we0 = 0; if_b1.we1 = 0;
    #1;
    checks++;
    if (if_b1.rd1 !== 32'h22) begin
      errors++;
      $display("FAIL prio_stored: rd1=%h expected 22", if_b1.rd1);
    end
    if_b1.ra2 = 5'd7;
    if_b1.we0 = 1; if_b1.wa0 = 5'd7; if_b1.wd0 = 32'h33;
    #1;
    checks++;
    if (if_b1.rd2 !== 32'h33) begin
      errors++;
      $display("FAIL port0_bypass: rd2=%h expected 33", if_b1.rd2);
    end
    tick();
    if_b1.we0 = 0;
    #1;
    checks++;
    if (if_b1.rd2 !== 32'h33 || if_b1.rd1 !== 32'h33) begin
      errors++;
      $display("FAIL port0_stored: rd1=%h rd2=%h expected 33/33", if_b1.rd1, if_b1.rd2);
    end
  endtask

  task automatic test_no_bypass();
    if_b0.ra1 = 5'd7;
    if_b0.we0 = 1; if_b0.wa0 = 5'd7; if_b0.wd0 = 32'h5A;
    #1;
    checks++;
    if (if_b0.rd1 !== 32'h0) begin
      errors++;
      $display("FAIL nobyp_first: rd1=%h expected 0", if_b0.rd1);
    end
    tick();
    if_b0.we1 = 1; if_b0.wa1 = 5'd7; if_b0.wd1 = 32'h22;
    if_b0.wd0 = 32'h11;
    #1;
    checks++;
    if (if_b0.rd1 !== 32'h5A) begin
      errors++;
      $display("FAIL nobyp_old: rd1=%h expected 5a", if_b0.rd1);
    end
    tick();
    if_b0.we0 = 0; if_b0.we1 = 0;
    if_b0.iss_we = 1; if_b0.iss_wa = 5'd4;
    #1;
    checks++;
    if (if_b0.rd1 !== 32'h22) begin
      errors++;
      $display("FAIL nobyp_new: rd1=%h expected 22", if_b0.rd1);
    end
    tick();
    if_b0.iss_we = 0;
    if_b0.ra2 = 5'd4;
    if_b0.we0 = 1; if_b0.wa0 = 5'd4; if_b0.wd0 = 32'h44;
    #1;
    checks++;
    if (if_b0.busy2 !== 1'b1 || if_b0.pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL nobyp_busy_hold: busy2=%b cnt=%0d expected 1/1", if_b0.busy2, if_b0.pend_cnt);
    end
    tick();
    if_b0.we0 = 0;
    #1;
    checks++;
    if (if_b0.busy2 !== 1'b0 || if_b0.pend_cnt !== 6'd0 || if_b0.rd2 !== 32'h44) begin
      errors++;
      $display("FAIL nobyp_busy_clr: busy2=%b cnt=%0d rd2=%h expected 0/0/44", if_b0.busy2, if_b0.pend_cnt, if_b0.rd2);
    end
  endtask

  task automatic test_scoreboard();
    if_b1.iss_we = 1; if_b1.iss_wa = 5'd3;
    tick();
    if_b1.iss_we = 0; if_b1.ra1 = 5'd3;
    #1;
    checks++;
    if (if_b1.busy1 !== 1'b1 || if_b1.pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL sb_issue: busy1=%b cnt=%0d expected 1/1", if_b1.busy1, if_b1.pend_cnt);
    end
    if_b1.we0 = 1; if_b1.wa0 = 5'd3; if_b1.wd0 = 32'hA5A5;
    #1;
    checks++;
    if (if_b1.busy1 !== 1'b0 || if_b1.pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL sb_wb_comb: busy1=%b cnt=%0d expected 0/1", if_b1.busy1, if_b1.pend_cnt);
    end
    tick();
    if_b1.we0 = 0;
    #1;
    checks++;
    if (if_b1.busy1 !== 1'b0 || if_b1.pend_cnt !== 6'd0 || if_b1.rd1 !== 32'hA5A5) begin
      errors++;
      $display("FAIL sb_wb_edge: busy1=%b cnt=%0d rd1=%h expected 0/0/a5a5", if_b1.busy1, if_b1.pend_cnt, if_b1.rd1);
    end
    // writeback to a register that is not pending must not set anything
    if_b1.we1 = 1; if_b1.wa1 = 5'd8; if_b1.wd1 = 32'h88;
    tick();
    if_b1.we1 = 0; if_b1.ra2 = 5'd8;
    #1;
    checks++;
    if (if_b1.busy2 !== 1'b0 || if_b1.pend_cnt !== 6'd0 || if_b1.rd2 !== 32'h88) begin
      errors++;
      $display("FAIL sb_wb_idle: busy2=%b cnt=%0d rd2=%h expected 0/0/88", if_b1.busy2, if_b1.pend_cnt, if_b1.rd2);
    end
  endtask

  task automatic test_collision();
    if_b1.iss_we = 1; if_b1.iss_wa = 5'd9;
    tick();
    if_b1.we1 = 1; if_b1.wa1 = 5'd9; if_b1.wd1 = 32'h99;
    tick();
    if_b1.iss_we = 0; if_b1.we1 = 0; if_b1.ra1 = 5'd9;
    #1;
    checks++;
    if (if_b1.busy1 !== 1'b1 || if_b1.pend_cnt !== 6'd1 || if_b1.rd1 !== 32'h99) begin
      errors++;
      $display("FAIL collision: busy1=%b cnt=%0d rd1=%h expected 1/1/99", if_b1.busy1, if_b1.pend_cnt, if_b1.rd1);
    end
    if_b1.iss_we = 1; if_b1.iss_wa = 5'd9;
    tick();
    if_b1.iss_we = 0;
    #1;
    checks++;
    if (if_b1.pend_cnt !== 6'd1) begin
      errors++;
      $display("FAIL reissue: cnt=%0d expected 1", if_b1.pend_cnt);
    end
    if_b1.we0 = 1; if_b1.wa0 = 5'd9;
    tick();
    if_b1.we0 = 0;
    #1;
    checks++;
    if (if_b1.pend_cnt !== 6'd0 || if_b1.busy1 !== 1'b0) begin
      errors++;
      $display("FAIL collision_clear: cnt=%0d busy1=%b expected 0/0", if_b1.pend_cnt, if_b1.busy1);
    end
  endtask

  task automatic test_fill();
    for (int r = 1; r < 32; r++) begin
      if_b1.iss_we = 1; if_b1.iss_wa = 5'(r);
      tick();
    end
    if_b1.iss_we = 0; if_b1.ra2 = 5'd31;
    #1;
    checks++;
    if (if_b1.pend_cnt !== 6'd31 || if_b1.busy2 !== 1'b1) begin
      errors++;
      $display("FAIL fill: cnt=%0d busy2=%b expected 31/1", if_b1.pend_cnt, if_b1.busy2);
    end
    if_b1.we0 = 1; if_b1.wa0 = 5'd1;
    if_b1.we1 = 1; if_b1.wa1 = 5'd2;
    tick();
    if_b1.we0 = 0; if_b1.we1 = 0;
    #1;
    checks++;
    if (if_b1.pend_cnt !== 6'd29) begin
      errors++;
      $display("FAIL dual_clear: cnt=%0d expected 29", if_b1.pend_cnt);
    end
  endtask

  task automatic test_range();
    if_n16.iss_we = 1; if_n16.iss_wa = 5'd15;
    tick();
    if_n16.iss_wa = 5'd20;
    tick();
    if_n16.iss_we = 0; if_n16.ra1 = 5'd20; if_n16.ra2 = 5'd15;
    if_n16.we1 = 1; if_n16.wa1 = 5'd20; if_n16.wd1 = 32'hABCD;
    #1;
    checks++;
    if (if_n16.pend_cnt !== 6'd1 || if_n16.rd1 !== 32'h0 || if_n16.busy1 !== 1'b0 || if_n16.busy2 !== 1'b1) begin
      errors++;
      $display("FAIL range_issue: cnt=%0d rd1=%h busy1=%b busy2=%b expected 1/0/0/1", if_n16.pend_cnt, if_n16.rd1, if_n16.busy1, if_n16.busy2);
    end
    tick();
    if_n16.we1 = 0;
    if_n16.we0 = 1; if_n16.wa0 = 5'd15; if_n16.wd0 = 32'hF15;
    tick();
    if_n16.we0 = 0;
    #1;
    checks++;
    if (if_n16.rd1 !== 32'h0 || if_n16.rd2 !== 32'hF15 || if_n16.pend_cnt !== 6'd0) begin
      errors++;
      $display("FAIL range_write: rd1=%h rd2=%h cnt=%0d expected 0/f15/0", if_n16.rd1, if_n16.rd2, if_n16.pend_cnt);
    end
  endtask

  initial begin
    idle_all();
    test_reset();
    test_zero_reg();
    test_priority_bypass();
    test_no_bypass();
    test_scoreboard();
    test_collision();
    test_fill();
    test_range();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: sim time exceeded, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised general-purpose register file with a built-in write-pending scoreboard, for the decode/writeback stages of the pipelined core. It provides two combinational read ports and two synchronous writeback ports, with an optional same-cycle write-to-read bypass. A per-register pending bit is set when an instruction that targets the register issues, and cleared when its result is written back. Register 0 is hardwired to zero and is never pending.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width
- NREG, 32, number of implemented registers; must satisfy 2 ≤ NREG ≤ 2^ADDR_W
- BYPASS, 1, 1 = same-cycle writeback data forwarded to the read ports; 0 = reads return the stored value only

- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  asynchronous reset, active-high
- ra1, ra2  in  ADDR_W  read addresses
- rd1, rd2  out  DATA_W  read data (combinational)
- busy1, busy2  out  1  pending status of ra1 / ra2 (combinational)
- we0, wa0, wd0  in  1 / ADDR_W / DATA_W  writeback port 0 (lower priority)
- we1, wa1, wd1  in  1 / ADDR_W / DATA_W  writeback port 1 (higher priority)
- iss_we, iss_wa  in  1 / ADDR_W  issue: mark register iss_wa pending
- pend_cnt  out  ADDR_W+1  number of registers currently pending (registered)

## Operation
- Storage: gpr[1..NREG-1] and pend[1..NREG-1]. Address 0 and addresses ≥ NREG are null.
  - Reads of a null address return 0 with busy = 0.
  - Writes, issues and clears to a null address are ignored.
- Write: on a rising edge, if weN = 1 and waN is not null, then gpr[waN] ← wdN.
  - If we0 and we1 target the same address, port 1's data is stored.
- Read, BYPASS = 1, for each read port:
  - if we1 is active and wa1 = ra, rd = wd1;
  - else if we0 is active and wa0 = ra, rd = wd0;
  - else rd = gpr[ra].
  - A null ra always yields 0, whatever the write ports carry.
- Read, BYPASS = 0: rd = gpr[ra]. The new value is visible in the cycle after the edge.
- Scoreboard update at each rising edge, per non-null register r:
  - set = iss_we and iss_wa = r;
  - clr = (we0 and wa0 = r) or (we1 and wa1 = r);
  - pend[r] ← set | (pend[r] & ~clr). When set and clr coincide, set wins: the new issue supersedes the older writeback.
- busy outputs:
  - BYPASS = 1: busy = pend[ra] & ~clr(ra). A result being written this cycle is already forwarded.
  - BYPASS = 0: busy = pend[ra].
- pend_cnt: registered population count of pend, updated on the same edge as pend, so it always equals popcount(pend).
  - Maximum value is NREG-1, which fits in ADDR_W+1 bits; the count cannot overflow.
- Issuing to a register that is already pending leaves it pending. pend_cnt does not change for that register.
- A writeback to a register that is not pending updates data only. The pend bit stays 0.

## Timing
- Reset (asynchronous, takes effect immediately):
  - all gpr = 0, all pend = 0, pend_cnt = 0;
  - therefore rd1 = rd2 = 0 and busy1 = busy2 = 0 while rst is high.
- Writes, issues and clears issued while rst is high are discarded.
- Reset asserted mid-operation: all pending state is lost. Release is synchronous to clk in the surrounding design.
- Latency:
  - write to read: 0 cycles with BYPASS = 1, 1 cycle with BYPASS = 0;
  - issue to busy: 1 cycle;
  - writeback to busy deassert: 0 cycles with BYPASS = 1, 1 cycle with BYPASS = 0.
- rd and busy are purely combinational from the address and write-port inputs. There are no internal paths from pend_cnt to them.
- No handshake or backpressure: every request is accepted in the cycle it is presented.

## Test plan
- Reset: write 0xDEADBEEF to r5, then pulse rst between edges. rd1 (ra1 = 5) must read 0 immediately, and pend_cnt must be 0.
- Zero register: we1 = 1, wa1 = 0, wd1 = 0xFFFFFFFF, iss_we = 1, iss_wa = 0. After the edge, rd1 (ra1 = 0) = 0, busy1 = 0, pend_cnt = 0.
- Port priority and bypass (BYPASS = 1): same cycle, we0 writes 0x11 to r7, we1 writes 0x22 to r7, ra1 = 7. rd1 = 0x22 in that cycle; after the edge, rd1 = 0x22.
  - Repeat with BYPASS = 0: rd1 shows the old value in that cycle and 0x22 after the edge.
- Scoreboard: issue r3 → busy(3) = 1 and pend_cnt = 1 after the edge.
  - Next cycle, we0 = 1, wa0 = 3 → busy(3) = 0 combinationally (BYPASS = 1), and pend_cnt = 0 after the edge.
- Set/clear collision: r9 pending; in the same cycle issue r9 and write back r9. After the edge, pend[9] = 1 and pend_cnt is unchanged.
- Fill and range check: issue every register 1..31, one per cycle. pend_cnt must reach 31.
  - With NREG = 16, ADDR_W = 5: issue r20 → pend_cnt is unchanged, and rd (ra = 20) = 0.
